// File: rtl/systolic_ctrl_if.sv
// Control/result bus between the systolic array sequencer and its host.
// Valid/ready: a result row transfers on a rising clk edge where out_valid && out_ready; out_valid/out_row hold until then.
interface systolic_ctrl_if #(
    parameter int N  = 4,
    parameter int KW = 5
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;

    logic          start;
    logic [KW-1:0] k_len;
    logic          busy;
    logic          clear_acc;
    logic [KW:0]   feed_t;
    logic [N-1:0]  row_valid;
    logic          out_valid;
    logic          out_ready;
    logic [RW-1:0] out_row;
    logic          done;

    modport master (
        output start, k_len, out_ready,
        input  busy, clear_acc, feed_t, row_valid, out_valid, out_row, done
    );

    modport slave (
        input  start, k_len, out_ready,
        output busy, clear_acc, feed_t, row_valid, out_valid, out_row, done
    );
endinterface

// File: rtl/systolic_ctrl.sv
// Sequencer for an N x N int8 MAC systolic array: clears accumulators, feeds
// skewed operands for K+N-1 cycles, flushes the PE pipeline, then drains result rows.
module systolic_ctrl #(
    parameter int N  = 4,
    parameter int KW = 5
) (
    input  logic            clk,
    input  logic            reset,
    systolic_ctrl_if.slave  bus,
    output logic [2:0]      state_dbg
);
    localparam int RW = (N > 1) ? $clog2(N) : 1;
    localparam int TW = KW + 1;

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_FLUSH = 3'd3;
    localparam logic [2:0] S_DRAIN = 3'd4;
    localparam logic [2:0] S_DONE  = 3'd5;

    logic [2:0]    state;
    logic [KW-1:0] k_q;
    logic [TW-1:0] t_q;
    logic [RW-1:0] row_q;
    logic [RW-1:0] fl_q;

    logic feed_last, flush_last, row_last;

    // Last FEED issue cycle is t = K+N-2; TW bits hold it even for K = 2^KW-1.
    assign feed_last  = (t_q == {1'b0, k_q} + TW'(N - 2));
    assign flush_last = (fl_q == RW'(N - 1));
    assign row_last   = (row_q == RW'(N - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
            k_q   <= '0;
            t_q   <= '0;
            row_q <= '0;
            fl_q  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.start) begin
                        k_q   <= bus.k_len;
                        state <= S_CLEAR;
                    end
                end
                S_CLEAR: begin
                    t_q   <= '0;
                    row_q <= '0;
                    state <= (k_q == '0) ? S_DRAIN : S_FEED;
                end
                S_FEED: begin
                    if (feed_last) begin
                        t_q   <= '0;
                        fl_q  <= '0;
                        state <= S_FLUSH;
                    end else begin
                        t_q <= t_q + TW'(1);
                    end
                end
                S_FLUSH: begin
                    if (flush_last) begin
                        row_q <= '0;
                        state <= S_DRAIN;
                    end else begin
                        fl_q <= fl_q + RW'(1);
                    end
                end
                S_DRAIN: begin
                    if (bus.out_ready) begin
                        if (row_last) begin
                            row_q <= '0;
                            state <= S_DONE;
                        end else begin
                            row_q <= row_q + RW'(1);
                        end
                    end
                end
                S_DONE:  state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    always_comb begin
        bus.busy      = (state != S_IDLE);
        bus.clear_acc = (state == S_CLEAR);
        bus.feed_t    = (state == S_FEED) ? t_q : '0;
        bus.out_valid = (state == S_DRAIN);
        bus.out_row   = row_q;
        bus.done      = (state == S_DONE);
        bus.row_valid = '0;
        // Diagonal skew: feeder i carries operands k = t-i for 0 <= k < K.
        if (state == S_FEED) begin
            for (int i = 0; i < N; i++) begin
                bus.row_valid[i] = (int'(t_q) >= i) && (int'(t_q) < i + int'(k_q));
            end
        end
    end

    assign state_dbg = state;
endmodule

// File: tb/tb_systolic_ctrl.sv
// Self-checking bench for systolic_ctrl: per-cycle comparison of every output
// against a phase-based reference model of a tile pass.
module tb_systolic_ctrl;
  localparam int N  = 4;
  localparam int KW = 5;
  localparam int RW = 2;
  localparam int FW = KW + 1;
  localparam int OW = 1 + 1 + FW + N + 1 + RW + 1;

  logic       clk = 1'b0;
  logic       reset;
  logic [2:0] state_dbg;

  systolic_ctrl_if #(.N(N), .KW(KW)) bus ();

  systolic_ctrl #(.N(N), .KW(KW)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // clock/reset block
  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;
  int busy_cycles;
  int max_feed_t;
  logic [OW-1:0] exp_q[$];
  bit ready_pat[7] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};

  function automatic logic [OW-1:0] actual_vec();
    return {bus.busy, bus.clear_acc, bus.feed_t, bus.row_valid,
            bus.out_valid, bus.out_row, bus.done};
  endfunction

  function automatic logic [OW-1:0] make_vec(input bit b, input bit c, input int ft,
                                             input logic [N-1:0] rv, input bit ov,
                                             input int orow, input bit d);
    return {b, c, FW'(ft), rv, ov, RW'(orow), d};
  endfunction

  // Driver + model: one full pass with K=k. ready_mode 0: always ready,
  // 1: random, 2: fixed pattern 1,0,0,1,1,0,1. poke pulses start mid-FEED and in DONE.
  task automatic run_pass(input int k, input int ready_mode, input bit poke, input string tag);
    int c, hs, dc, f_len, l_len, t;
    bit fin, in_drain, rdy;
    logic [N-1:0] rv;
    logic [OW-1:0] e, a, x;
    @(negedge clk);
    n_tests++;
    if (actual_vec() !== '0) begin
      n_fail++;
      $display("FAIL %s idle_before_start: got %h expected %h", tag, actual_vec(), {OW{1'b0}});
    end
    bus.start     = 1'b1;
    bus.k_len     = KW'(k);
    bus.out_ready = 1'($urandom_range(0, 1));
    f_len = (k > 0) ? k + N - 1 : 0;
    l_len = (k > 0) ? N : 0;
    hs = 0; dc = 0; c = 0; fin = 0;
    busy_cycles = 0; max_feed_t = 0;
    while (!fin) begin
      @(negedge clk);
      bus.start = (poke && c == 2);
      bus.k_len = KW'($urandom);
      rv = '0;
      in_drain = 0;
      if (c == 0) begin
        e = make_vec(1, 1, 0, '0, 0, 0, 0);
      end else if (c <= f_len) begin
        t = c - 1;
        for (int i = 0; i < N; i++) rv[i] = (t >= i) && (t < i + k);
        e = make_vec(1, 0, t, rv, 0, 0, 0);
      end else if (c <= f_len + l_len) begin
        e = make_vec(1, 0, 0, '0, 0, 0, 0);
      end else if (hs < N) begin
        e = make_vec(1, 0, 0, '0, 1, hs, 0);
        in_drain = 1;
      end else begin
        e = make_vec(1, 0, 0, '0, 0, 0, 1);
        fin = 1;
      end
      exp_q.push_back(e);
      a = actual_vec();
      if (bus.busy) busy_cycles++;
      if (int'(bus.feed_t) > max_feed_t) max_feed_t = int'(bus.feed_t);
      x = exp_q.pop_front();
      n_tests++;
      if (a !== x) begin
        n_fail++;
        $display("FAIL %s cycle %0d: got %h expected %h", tag, c, a, x);
      end
      if (in_drain) begin
        case (ready_mode)
          0:       rdy = 1'b1;
          2:       rdy = ready_pat[dc % 7];
          default: rdy = 1'($urandom_range(0, 1));
        endcase
        dc++;
        if (rdy) hs++;
      end else begin
        rdy = 1'($urandom_range(0, 1));
      end
      bus.out_ready = rdy;
      if (fin && poke) bus.start = 1'b1;
      c++;
      if (!fin && c > 400) begin
        n_tests++;
        n_fail++;
        $display("FAIL %s timeout: got no done after %0d cycles expected done", tag, c);
        fin = 1;
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    bus.start = 1'b0;
    bus.k_len = '0;
    bus.out_ready = 1'b0;
    #1;
    n_tests++;
    if (actual_vec() !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got %h expected %h", actual_vec(), {OW{1'b0}});
    end
    repeat (3) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      bus.k_len = KW'($urandom);
      bus.out_ready = 1'($urandom_range(0, 1));
      n_tests++;
      if (actual_vec() !== '0) begin
        n_fail++;
        $display("FAIL post_reset_idle %0d: got %h expected %h", i, actual_vec(), {OW{1'b0}});
      end
    end
  endtask

  task automatic test_basic();
    run_pass(3, 0, 0, "basic_k3");
    n_tests++;
    if (busy_cycles !== 16) begin
      n_fail++;
      $display("FAIL basic_busy_cycles: got %0d expected %0d", busy_cycles, 16);
    end
  endtask

  task automatic test_k_zero();
    run_pass(0, 0, 0, "k_zero");
    n_tests++;
    if (busy_cycles !== N + 2) begin
      n_fail++;
      $display("FAIL k_zero_busy_cycles: got %0d expected %0d", busy_cycles, N + 2);
    end
  endtask

  task automatic test_ready_pattern();
    run_pass(2, 2, 0, "ready_pattern");
  endtask

  task automatic test_ignore_start();
    run_pass(4, 0, 1, "ignore_start_a");
    run_pass(1, 1, 0, "ignore_start_b");
  endtask

  task automatic test_max_k();
    run_pass(31, 0, 0, "max_k");
    n_tests++;
    if (max_feed_t !== 33) begin
      n_fail++;
      $display("FAIL max_k_feed_t: got %0d expected %0d", max_feed_t, 33);
    end
  endtask

  task automatic test_random();
    for (int p = 0; p < 8; p++) begin
      run_pass($urandom_range(0, 12), 1, 1'($urandom_range(0, 1)), "random");
    end
  endtask

  task automatic test_reset_mid_feed();
    bit found;
    @(negedge clk);
    bus.start = 1'b1;
    bus.k_len = KW'(5);
    found = 0;
    for (int i = 0; i < 20 && !found; i++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.feed_t == FW'(2)) found = 1;
    end
    n_tests++;
    if (!found) begin
      n_fail++;
      $display("FAIL mid_feed_reach: got no feed_t=2 expected feed_t=2");
    end
    #2 reset = 1'b0;
    #1;
    n_tests++;
    if (actual_vec() !== '0) begin
      n_fail++;
      $display("FAIL async_reset: got %h expected %h", actual_vec(), {OW{1'b0}});
    end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.k_len = KW'($urandom);
      n_tests++;
      if (actual_vec() !== '0) begin
        n_fail++;
        $display("FAIL mid_feed_post_reset %0d: got %h expected %h", i, actual_vec(), {OW{1'b0}});
      end
    end
    run_pass(3, 1, 0, "after_reset");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_k_zero();
    test_ready_pattern();
    test_ignore_start();
    test_max_k();
    test_random();
    test_reset_mid_feed();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
